battle_turn_scheduler: RTL and testbench

BATTLE_TURN_SCHEDULER -- requirements
Module: battle_turn_scheduler

---
 rtl/battle_turn_scheduler.sv | 132 +++++++++++++
 tb/tb_battle_turn_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/battle_turn_scheduler.sv
// Turn sequencer for a two-Pokemon battle: orders attacks by speed, runs the
// req/ack handshake with a shared damage unit and applies saturating HP loss.
module battle_turn_scheduler #(
    parameter logic [3:0] HP_INIT = 4'd15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       p_valid,
    input  logic [1:0] p_move,
    input  logic [3:0] p_speed,
    input  logic       ai_valid,
    input  logic [1:0] ai_move,
    input  logic [3:0] ai_speed,
    output logic       in_ready,
    output logic       dmg_req,
    output logic       dmg_attacker,
    output logic [1:0] dmg_move,
    input  logic       dmg_ack,
    input  logic [3:0] dmg_value,
    output logic [3:0] p_hp,
    output logic [3:0] ai_hp,
    output logic       turn_done,
    output logic       victory,
    output logic       loss
);

    typedef enum logic [3:0] {
        IDLE, REQ1, APPLY1, CHECK1, REQ2, APPLY2, CHECK2, TURN_END, VICTORY, LOSS
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] p_hp_q, p_hp_d, ai_hp_q, ai_hp_d;
    logic [3:0] p_speed_q, p_speed_d, ai_speed_q, ai_speed_d;
    logic [1:0] p_move_q, p_move_d, ai_move_q, ai_move_d;
    logic [3:0] dmg_q, dmg_d;
    logic       tie_pref_q, tie_pref_d;
    logic       first_att, cur_att, second_half;

    function automatic logic [3:0] sat_sub(input logic [3:0] hp, input logic [3:0] dmg);
        return (dmg >= hp) ? 4'd0 : hp - dmg;
    endfunction

    // tie_pref has already toggled at accept on a tie, so the turn's own tie winner is its inverse
    always_comb begin
        if (p_speed_q > ai_speed_q)      first_att = 1'b0;
        else if (p_speed_q < ai_speed_q) first_att = 1'b1;
        else                             first_att = ~tie_pref_q;
    end

    assign second_half = (state_q == REQ2) || (state_q == APPLY2) || (state_q == CHECK2);
    assign cur_att     = second_half ? ~first_att : first_att;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            p_hp_q     <= HP_INIT;
            ai_hp_q    <= HP_INIT;
            tie_pref_q <= 1'b0;
            p_speed_q  <= '0;
            ai_speed_q <= '0;
            p_move_q   <= '0;
            ai_move_q  <= '0;
            dmg_q      <= '0;
        end else begin
            state_q    <= state_d;
            p_hp_q     <= p_hp_d;
            ai_hp_q    <= ai_hp_d;
            tie_pref_q <= tie_pref_d;
            p_speed_q  <= p_speed_d;
            ai_speed_q <= ai_speed_d;
            p_move_q   <= p_move_d;
            ai_move_q  <= ai_move_d;
            dmg_q      <= dmg_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        p_hp_d     = p_hp_q;
        ai_hp_d    = ai_hp_q;
        tie_pref_d = tie_pref_q;
        p_speed_d  = p_speed_q;
        ai_speed_d = ai_speed_q;
        p_move_d   = p_move_q;
        ai_move_d  = ai_move_q;
        dmg_d      = dmg_q;
        case (state_q)
            IDLE: begin
                if (p_valid && ai_valid) begin
                    p_speed_d  = p_speed;
                    ai_speed_d = ai_speed;
                    p_move_d   = p_move;
                    ai_move_d  = ai_move;
                    if (p_speed == ai_speed) tie_pref_d = ~tie_pref_q;
                    state_d = REQ1;
                end
            end
            REQ1, REQ2: begin
                if (dmg_ack) begin
                    dmg_d   = dmg_value;
                    state_d = (state_q == REQ1) ? APPLY1 : APPLY2;
                end
            end
            APPLY1, APPLY2: begin
                if (cur_att) p_hp_d  = sat_sub(p_hp_q, dmg_q);
                else         ai_hp_d = sat_sub(ai_hp_q, dmg_q);
                state_d = (state_q == APPLY1) ? CHECK1 : CHECK2;
            end
            CHECK1, CHECK2: begin
                if (!cur_att && ai_hp_q == 4'd0)     state_d = VICTORY;
                else if (cur_att && p_hp_q == 4'd0)  state_d = LOSS;
                else if (state_q == CHECK1)          state_d = REQ2;
                else                                 state_d = TURN_END;
            end
            TURN_END: state_d = IDLE;
            default:  state_d = state_q;
        endcase
    end

    always_comb begin
        in_ready     = (state_q == IDLE);
        dmg_req      = (state_q == REQ1) || (state_q == REQ2);
        dmg_attacker = cur_att;
        dmg_move     = cur_att ? ai_move_q : p_move_q;
        turn_done    = (state_q == TURN_END);
        victory      = (state_q == VICTORY);
        loss         = (state_q == LOSS);
        p_hp         = p_hp_q;
        ai_hp        = ai_hp_q;
    end

endmodule

// File: tb/tb_battle_turn_scheduler.sv
// Directed bench: table of full turns carried across HP state, plus victory,
// loss and stall/reset sequences.
module tb_battle_turn_scheduler;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       p_valid = 1'b0, ai_valid = 1'b0;
    logic [1:0] p_move = '0, ai_move = '0;
    logic [3:0] p_speed = '0, ai_speed = '0;
    logic       in_ready, dmg_req, dmg_attacker;
    logic [1:0] dmg_move;
    logic       dmg_ack = 1'b0;
    logic [3:0] dmg_value = '0;
    logic [3:0] p_hp, ai_hp;
    logic       turn_done, victory, loss;

    battle_turn_scheduler #(.HP_INIT(4'd15)) dut (
        .clk(clk), .reset_n(reset_n),
        .p_valid(p_valid), .p_move(p_move), .p_speed(p_speed),
        .ai_valid(ai_valid), .ai_move(ai_move), .ai_speed(ai_speed),
        .in_ready(in_ready), .dmg_req(dmg_req), .dmg_attacker(dmg_attacker),
        .dmg_move(dmg_move), .dmg_ack(dmg_ack), .dmg_value(dmg_value),
        .p_hp(p_hp), .ai_hp(ai_hp), .turn_done(turn_done),
        .victory(victory), .loss(loss)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;

    typedef struct {
        logic [3:0] ps, as;
        logic [1:0] pm, am;
        logic [3:0] d1, d2;
        logic       first;
        logic [3:0] exp_php, exp_aihp;
    } vec_t;

    vec_t tv[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic accept(input logic [3:0] ps, input logic [3:0] as,
                          input logic [1:0] pm, input logic [1:0] am);
        p_speed = ps; ai_speed = as; p_move = pm; ai_move = am;
        p_valid = 1'b1; ai_valid = 1'b1;
        tick();
        acc_cyc = cyc;
        p_valid = 1'b0; ai_valid = 1'b0;
    endtask

    task automatic serve(input logic [3:0] d, output logic att, output logic [1:0] mv);
        bit ok = 0;
        att = 1'bx; mv = 2'bxx;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (dmg_req === 1'b1) ok = 1;
            else tick();
        end
        if (!ok) begin
            check("req_timeout", 0, 1);
        end else begin
            att = dmg_attacker; mv = dmg_move;
            dmg_ack = 1'b1; dmg_value = d;
            tick();
            dmg_ack = 1'b0; dmg_value = '0;
        end
    endtask

    task automatic finish_turn(input string tag);
        int dt = -1;
        for (int i = 0; i < 20 && dt < 0; i++) begin
            if (turn_done === 1'b1) dt = cyc - acc_cyc;
            else tick();
        end
        check({tag, "_done_at"}, dt, 6);
        tick();
        check({tag, "_idle"}, in_ready, 1);
        check({tag, "_done_1cyc"}, turn_done, 0);
    endtask

    logic       a1, a2;
    logic [1:0] m1, m2;
    int         errs;
    int         extra;

    initial begin
        tv[0] = '{ps:9,  as:4, pm:1, am:2, d1:5, d2:5, first:0, exp_php:10, exp_aihp:10};
        tv[1] = '{ps:6,  as:6, pm:0, am:3, d1:0, d2:2, first:0, exp_php:8,  exp_aihp:10};
        tv[2] = '{ps:6,  as:6, pm:2, am:1, d1:3, d2:1, first:1, exp_php:5,  exp_aihp:9};
        tv[3] = '{ps:3,  as:7, pm:3, am:0, d1:1, d2:2, first:1, exp_php:4,  exp_aihp:7};
        tv[4] = '{ps:6,  as:6, pm:1, am:1, d1:2, d2:1, first:0, exp_php:3,  exp_aihp:5};
        tv[5] = '{ps:15, as:0, pm:2, am:3, d1:0, d2:0, first:0, exp_php:3,  exp_aihp:5};

        tick();
        do_reset();
        check("rst_in_ready", in_ready, 1);
        check("rst_dmg_req", dmg_req, 0);
        check("rst_flags", {turn_done, victory, loss}, 0);
        check("rst_p_hp", p_hp, 15);
        check("rst_ai_hp", ai_hp, 15);

        for (int i = 0; i < 6; i++) begin
            accept(tv[i].ps, tv[i].as, tv[i].pm, tv[i].am);
            serve(tv[i].d1, a1, m1);
            check($sformatf("t%0d_att1", i), a1, tv[i].first);
            check($sformatf("t%0d_mv1", i), m1, tv[i].first ? tv[i].am : tv[i].pm);
            serve(tv[i].d2, a2, m2);
            check($sformatf("t%0d_att2", i), a2, !tv[i].first);
            check($sformatf("t%0d_mv2", i), m2, tv[i].first ? tv[i].pm : tv[i].am);
            finish_turn($sformatf("t%0d", i));
            check($sformatf("t%0d_p_hp", i), p_hp, tv[i].exp_php);
            check($sformatf("t%0d_ai_hp", i), ai_hp, tv[i].exp_aihp);
        end

        // victory with saturation: 15-11 = 4, then 4-9 saturates to 0
        do_reset();
        accept(9, 2, 1, 0);
        serve(11, a1, m1);
        serve(0, a2, m2);
        finish_turn("v_pre");
        check("v_pre_ai_hp", ai_hp, 4);
        accept(9, 2, 3, 0);
        serve(9, a1, m1);
        check("v_att", a1, 0);
        extra = 0;
        for (int i = 0; i < 10 && victory !== 1'b1; i++) begin
            if (dmg_req || turn_done) extra++;
            tick();
        end
        check("v_victory", victory, 1);
        check("v_ai_hp", ai_hp, 0);
        check("v_no_extra", extra, 0);
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            p_valid = i[0]; ai_valid = ~i[1]; dmg_ack = i[0]; dmg_value = 4'd3;
            tick();
            if (victory !== 1'b1 || loss || dmg_req || turn_done || in_ready ||
                ai_hp !== 4'd0 || p_hp !== 4'd15) errs++;
        end
        p_valid = 0; ai_valid = 0; dmg_ack = 0; dmg_value = 0;
        check("v_hold", errs, 0);

        // loss: AI faster, 15-12 = 3, then exactly 3
        do_reset();
        accept(1, 9, 2, 3);
        serve(12, a1, m1);
        check("l_pre_att", a1, 1);
        serve(0, a2, m2);
        finish_turn("l_pre");
        check("l_pre_p_hp", p_hp, 3);
        accept(1, 9, 2, 1);
        serve(3, a1, m1);
        check("l_att", a1, 1);
        check("l_mv", m1, 1);
        extra = 0;
        for (int i = 0; i < 10 && loss !== 1'b1; i++) begin
            if (dmg_req || turn_done) extra++;
            tick();
        end
        check("l_loss", loss, 1);
        check("l_p_hp", p_hp, 0);
        check("l_no_player_req", extra, 0);
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            p_valid = ~i[0]; ai_valid = 1'b1;
            tick();
            if (loss !== 1'b1 || victory || dmg_req || in_ready || p_hp !== 4'd0) errs++;
        end
        p_valid = 0; ai_valid = 0;
        check("l_hold", errs, 0);

        // single-sided valid, stall, reset mid-handshake, late ack
        do_reset();
        p_speed = 5; ai_speed = 5;
        p_valid = 1'b1;
        tick(); tick();
        p_valid = 1'b0; ai_valid = 1'b1;
        tick();
        ai_valid = 1'b0;
        check("s_single_valid", {in_ready, dmg_req}, 2'b10);
        accept(9, 1, 2, 0);
        serve(4, a1, m1);
        serve(4, a2, m2);
        finish_turn("s_pre");
        check("s_pre_hp", {p_hp, ai_hp}, {4'd11, 4'd11});
        accept(2, 8, 3, 1);
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            if (dmg_req !== 1'b1 || dmg_attacker !== 1'b1 || dmg_move !== 2'd1) errs++;
            tick();
        end
        check("s_stall_stable", errs, 0);
        check("s_stall_req", dmg_req, 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("s_rst_req", dmg_req, 0);
        check("s_rst_ready", in_ready, 1);
        check("s_rst_hp", {p_hp, ai_hp}, {4'd15, 4'd15});
        dmg_ack = 1'b1; dmg_value = 4'd7;
        tick();
        dmg_ack = 1'b0; dmg_value = 4'd0;
        tick();
        check("s_late_ack", {in_ready, dmg_req, p_hp, ai_hp}, {2'b10, 4'd15, 4'd15});
        accept(6, 6, 0, 2);
        serve(1, a1, m1);
        check("s_tie_after_rst", a1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
